// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared constants, FSM encoding and forwarding helper for the
//               pipeline hazard scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    localparam int REG_AW_DEF  = 5;
    localparam int MAX_LAT_DEF = 15;
    localparam int CNT_W_DEF   = 16;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LD_STALL = 2'b01,
        ST_SB_STALL = 2'b10
    } hz_state_e;

    // MEM result is younger than WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
        if (mem_hit) return FWD_MEM;
        if (wb_hit)  return FWD_WB;
        return FWD_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hz_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hz_scoreboard
// Description : Per-register latency down-counters for multicycle ops, with a
//               registered completion pulse and sticky issue-error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module hz_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int MAX_LAT = MAX_LAT_DEF,
    localparam int LAT_W  = $clog2(MAX_LAT + 1),
    localparam int NREG   = 2 ** REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mc_issue,
    input  logic [REG_AW-1:0] mc_rd,
    input  logic [LAT_W-1:0]  mc_lat,
    output logic [NREG-1:0]   pending,
    output logic              mc_wb_valid,
    output logic [REG_AW-1:0] mc_wb_rd,
    output logic              err_issue
);

    logic              rd_nz;
    logic              lat_ok;
    logic              rd_busy;
    logic              issue_ok;
    logic              issue_bad;
    logic [NREG-1:0]   done;
    logic              multi_done;
    logic [REG_AW-1:0] first_rd;
    logic              wb_valid_q;
    logic [REG_AW-1:0] wb_rd_q;
    logic              err_q;

    assign rd_nz     = (mc_rd != '0);
    assign lat_ok    = (mc_lat != '0) && (mc_lat <= LAT_W'(MAX_LAT));
    assign rd_busy   = pending[mc_rd];
    assign issue_ok  = mc_issue && rd_nz && lat_ok && !rd_busy;
    assign issue_bad = mc_issue && rd_nz && (!lat_ok || rd_busy);

    for (genvar i = 0; i < NREG; i++) begin : g_entry
        logic [LAT_W-1:0] cnt_q;
        logic [LAT_W-1:0] cnt_d;

        assign pending[i] = (cnt_q != '0);
        assign done[i]    = (cnt_q == LAT_W'(1));

        always_comb begin
            cnt_d = cnt_q;
            if (issue_ok && (mc_rd == REG_AW'(i))) begin
                cnt_d = mc_lat;
            end else if (pending[i]) begin
                cnt_d = cnt_q - LAT_W'(1);
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_done = |(done & (done - NREG'(1)));

    always_comb begin
        first_rd = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (done[i]) first_rd = REG_AW'(i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            wb_valid_q <= |done;
            wb_rd_q    <= first_rd;
            err_q      <= err_q | issue_bad | multi_done;
        end
    end

    assign mc_wb_valid = wb_valid_q;
    assign mc_wb_rd    = wb_rd_q;
    assign err_issue   = err_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_scoreboard
// Description : EX operand forwarding, load-use and multicycle scoreboard
//               stall control, hazard FSM and stall statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int MAX_LAT = MAX_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    localparam int LAT_W  = $clog2(MAX_LAT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rd_valid,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    input  logic              mc_issue,
    input  logic [REG_AW-1:0] mc_rd,
    input  logic [LAT_W-1:0]  mc_lat,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              pc_enable,
    output logic              if_id_enable,
    output logic              id_ex_bubble,
    output logic              mc_wb_valid,
    output logic [REG_AW-1:0] mc_wb_rd,
    output logic [CNT_W-1:0]  stall_count,
    output logic              err_issue
);

    localparam int NREG = 2 ** REG_AW;

    logic [NREG-1:0]  pending;
    logic             mem_ok;
    logic             wb_ok;
    logic             ld_hazard;
    logic             sb_hazard;
    logic             stall;
    hz_state_e        state_q;
    hz_state_e        state_d;
    hz_state_e        hz_src;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    hz_scoreboard #(
        .REG_AW  (REG_AW),
        .MAX_LAT (MAX_LAT)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .mc_issue    (mc_issue),
        .mc_rd       (mc_rd),
        .mc_lat      (mc_lat),
        .pending     (pending),
        .mc_wb_valid (mc_wb_valid),
        .mc_wb_rd    (mc_wb_rd),
        .err_issue   (err_issue)
    );

    // ex_regwrite only matters to later stages; forwarding keys on MEM/WB.
    assign mem_ok = mem_regwrite && (mem_rd != '0);
    assign wb_ok  = wb_regwrite && (wb_rd != '0);
    assign fwd_a  = fwd_sel(mem_ok && (mem_rd == ex_rs), wb_ok && (wb_rd == ex_rs));
    assign fwd_b  = fwd_sel(mem_ok && (mem_rd == ex_rt), wb_ok && (wb_rd == ex_rt));

    assign ld_hazard = ex_memread && (ex_rd != '0) &&
                       ((id_rs_used && (ex_rd == id_rs)) || (id_rt_used && (ex_rd == id_rt)));
    assign sb_hazard = (id_rs_used && pending[id_rs]) ||
                       (id_rt_used && pending[id_rt]) ||
                       (id_rd_valid && pending[id_rd]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        hz_src = ST_RUN;
        if (ld_hazard) begin
            hz_src = ST_LD_STALL;
        end else if (sb_hazard) begin
            hz_src = ST_SB_STALL;
        end
        state_d = ST_RUN;
        case (state_q)
            ST_RUN, ST_LD_STALL, ST_SB_STALL: state_d = hz_src;
            default:                          state_d = ST_RUN;
        endcase
    end

    always_comb begin
        stall        = (state_d != ST_RUN);
        pc_enable    = !stall;
        if_id_enable = !stall;
        id_ex_bubble = stall;
    end

    assign stall_cnt_d = (id_ex_bubble && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;

endmodule
`default_nettype wire
